// File: rtl/spimem_arb_pkg.sv
// Shared types and constants for the spimemio read-port arbiter.
package spimem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  localparam logic        PORT_BOOT = 1'b0;
  localparam logic        PORT_CPU  = 1'b1;
  localparam logic [31:0] ERR_WORD  = 32'hFFFF_FFFF;
  localparam int          TAG_W     = 22;

  function automatic logic [23:0] word_addr(input logic [TAG_W-1:0] tag);
    return {tag, 2'b00};
  endfunction

endpackage

// File: rtl/spimem_wordcache.sv
// Single-entry flash word cache: one tag, one data word, one valid bit.
module spimem_wordcache
  import spimem_arb_pkg::*;
#(
  parameter int CACHE_EN = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  output logic [31:0]      hit_data,
  input  logic             fill,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [31:0]      fill_data,
  input  logic             inv
);

  logic             cvalid;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      data_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cvalid <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      if (fill) begin
        tag_q  <= fill_tag;
        data_q <= fill_data;
      end
      // An invalidate in the fill cycle must leave the entry empty.
      if (inv)
        cvalid <= 1'b0;
      else if (fill)
        cvalid <= 1'b1;
    end
  end

  assign hit      = (CACHE_EN != 0) && cvalid && (tag_q == lookup_tag);
  assign hit_data = data_q;

endmodule

// File: rtl/spimem_arbiter.sv
// Two-port arbiter in front of spimemio: grant, cache lookup, flash handshake, timeout abort.
//   state | meaning
//   IDLE  | sample requests, pick grant, look up cache
//   FETCH | flash_valid high, waiting for flash_ready or timeout
//   RESP  | one-cycle ready (and err on abort) to the granted port
module spimem_arbiter
  import spimem_arb_pkg::*;
#(
  parameter int ARB_FIXED   = 0,
  parameter int CACHE_EN    = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        r0_valid,
  input  logic [23:0] r0_addr,
  output logic        r0_ready,
  input  logic        r1_valid,
  input  logic [23:0] r1_addr,
  output logic        r1_ready,
  output logic [31:0] rdata,
  output logic        err,
  input  logic        cache_inv,
  output logic        busy,
  output logic        flash_valid,
  output logic [23:0] flash_addr,
  input  logic        flash_ready,
  input  logic [31:0] flash_rdata
);

  localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);

  arb_state_e       state;
  logic             grant;
  logic             last_grant;
  logic [TAG_W-1:0] word_q;
  logic [TW-1:0]    tmr;

  logic             pick;
  logic [TAG_W-1:0] pick_tag;
  logic             cache_hit;
  logic             hit_now;
  logic [31:0]      cache_data;
  logic             cache_fill;
  logic             gvalid;

  always_comb begin
    pick = PORT_BOOT;
    if (ARB_FIXED != 0)
      pick = r0_valid ? PORT_BOOT : PORT_CPU;
    else if (r0_valid && r1_valid)
      pick = ~last_grant;
    else
      pick = r0_valid ? PORT_BOOT : PORT_CPU;
  end

  assign pick_tag   = (pick == PORT_CPU) ? r1_addr[23:2] : r0_addr[23:2];
  assign hit_now    = cache_hit && !cache_inv;
  assign cache_fill = (state == FETCH) && flash_ready;
  assign gvalid     = (grant == PORT_CPU) ? r1_valid : r0_valid;
  assign busy       = (state == FETCH);

  spimem_wordcache #(
    .CACHE_EN (CACHE_EN)
  ) u_cache (
    .clk        (clk),
    .resetn     (resetn),
    .lookup_tag (pick_tag),
    .hit        (cache_hit),
    .hit_data   (cache_data),
    .fill       (cache_fill),
    .fill_tag   (word_q),
    .fill_data  (flash_rdata),
    .inv        (cache_inv)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      grant       <= PORT_BOOT;
      last_grant  <= PORT_CPU;
      word_q      <= '0;
      tmr         <= '0;
      flash_valid <= 1'b0;
      flash_addr  <= '0;
      rdata       <= '0;
      r0_ready    <= 1'b0;
      r1_ready    <= 1'b0;
      err         <= 1'b0;
    end else begin
      r0_ready <= 1'b0;
      r1_ready <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (r0_valid || r1_valid) begin
            grant      <= pick;
            last_grant <= pick;
            word_q     <= pick_tag;
            if (hit_now) begin
              rdata    <= cache_data;
              r0_ready <= (pick == PORT_BOOT);
              r1_ready <= (pick == PORT_CPU);
              state    <= RESP;
            end else begin
              flash_valid <= 1'b1;
              flash_addr  <= word_addr(pick_tag);
              tmr         <= TMR_LOAD;
              state       <= FETCH;
            end
          end
        end
        FETCH: begin
          if (flash_ready || tmr == '0) begin
            flash_valid <= 1'b0;
            state       <= RESP;
            // A requester that walked away still gets its word cached, but no pulse.
            if (gvalid) begin
              rdata    <= flash_ready ? flash_rdata : ERR_WORD;
              r0_ready <= (grant == PORT_BOOT);
              r1_ready <= (grant == PORT_CPU);
              err      <= !flash_ready;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
